// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word size
// and default geometry/latency.
package data_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES      = 4;
    localparam int CNT_W           = 4;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 3;

endpackage

// File: rtl/dm_word_array.sv
// Single-port word storage: synchronous write, asynchronous read.
module dm_word_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory with fixed multi-cycle latency; stalls the pipeline
// while an access is outstanding and pulses a one-cycle response.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               addr_err;
    logic               mem_we;
    logic [31:0]        mem_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? S_BUSY : S_RESP;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are data, not control: they carry no reset.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (IDX_W + 2)) != 32'd0);

    // A reset landing on the RESP edge drops the store along with the response.
    assign mem_we = (state_q == S_RESP) && wr_q && !addr_err && rst;

    dm_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .we_i   (mem_we),
        .addr_i (addr_q[IDX_W+1:2]),
        .wdata_i(wdata_q),
        .rdata_o(mem_rdata)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid && addr_err;
    assign resp_rdata = (resp_valid && !wr_q && !addr_err) ? mem_rdata : 32'd0;
    assign stall      = ((state_q == S_IDLE) && req_valid) || (state_q == S_BUSY);

endmodule
